// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control sequencer
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       ext_zero,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_e;

  state_e state_q, state_d;

  logic [2:0] r_alu;
  logic       r_ok;

  // Raw enables before the reset override on write strobes
  logic pc_en_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  // R-type funct to ALU operation, flagging unsupported functs
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH without waiting for an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore/gated control decode
  always_comb begin
    state_d       = state_q;
    pc_en_raw     = 1'b0;
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = 3'b000;
    pc_src        = 2'b00;
    ext_zero      = 1'b0;
    retire        = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        alu_control  = ALU_ADD;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = r_ok ? S_EXEC_R : S_HALT;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_ORI:  state_d = S_IMMEXEC;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe held for the whole wait; retires on the completing cycle
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en_raw   = zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_IMMEXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        ext_zero    = (op == OP_ORI);
        state_d     = S_IMMWB;
      end
      S_IMMWB: begin
        // IR is stable, so ext_zero naturally holds the IMMEXEC choice
        reg_write_raw = 1'b1;
        ext_zero      = (op == OP_ORI);
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are suppressed while reset is held
  assign pc_en     = pc_en_raw     & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign ir_write  = ir_write_raw  & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk, reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, retire, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .ext_zero(ext_zero),
    .state(state), .retire(retire), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [17:0] ctl = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, alu_control, pc_src, ext_zero, retire, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] cv(input logic pe, io, mw, iw, rd, mr, rw, sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] ps, input logic ez, rt, il);
    return {pe, io, mw, iw, rd, mr, rw, sa, sb, alu, ps, ez, rt, il};
  endfunction

  // Called just after a falling edge with inputs already set
  task automatic cyc(input string tag, input int st, input logic [17:0] exp);
    #1;
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".ctl"}, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f; mem_ready = 1'b1;
    cyc({tag, ".fetch"},  0, cv(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,0,0));
    cyc({tag, ".decode"}, 1, cv(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.ctl", 32'(ctl), 32'(cv(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0)));
    @(negedge clk);
    reset = 1'b0;

    // LW, zero wait states: 0,1,2,3,4
    fetch_decode("lw", 6'b100011, 6'd0);
    cyc("lw.memadr", 2, cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
    cyc("lw.memrd",  3, cv(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0));
    cyc("lw.memwb",  4, cv(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1,0));

    // SW with one FETCH wait and three MEMWR waits
    op = 6'b101011; mem_ready = 1'b0;
    cyc("sw.fetchwait", 0, cv(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0));
    fetch_decode("sw", 6'b101011, 6'd0);
    cyc("sw.memadr", 2, cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      cyc("sw.memwr_wait", 5, cv(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0));
    end
    mem_ready = 1'b1;
    cyc("sw.memwr_done", 5, cv(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,1,0));

    // ORI then ADDI
    fetch_decode("ori", 6'b001101, 6'd0);
    cyc("ori.exec", 9,  cv(0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,1,0,0));
    cyc("ori.wb",   10, cv(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,1,1,0));
    fetch_decode("addi", 6'b001000, 6'd0);
    cyc("addi.exec", 9,  cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
    cyc("addi.wb",   10, cv(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0));

    // BEQ taken then not taken
    zero = 1'b1;
    fetch_decode("beq1", 6'b000100, 6'd0);
    cyc("beq1.branch", 8, cv(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1,0));
    zero = 1'b0;
    fetch_decode("beq0", 6'b000100, 6'd0);
    cyc("beq0.branch", 8, cv(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1,0));

    // J
    fetch_decode("j", 6'b000010, 6'd0);
    cyc("j.jump", 11, cv(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,1,0));

    // R-type SLT and SUB
    fetch_decode("slt", 6'b000000, 6'b101010);
    cyc("slt.exec", 6, cv(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0,0));
    cyc("slt.wb",   7, cv(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1,0));
    fetch_decode("sub", 6'b000000, 6'b100010);
    cyc("sub.exec", 6, cv(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0,0));
    cyc("sub.wb",   7, cv(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1,0));

    // Illegal opcode halts and stays halted
    fetch_decode("ill", 6'b111111, 6'd0);
    for (int i = 0; i < 10; i++)
      cyc("ill.halt", 15, cv(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,1));

    // Unsupported R-type funct also halts
    do_reset();
    fetch_decode("badfn", 6'b000000, 6'b000000);
    cyc("badfn.halt", 15, cv(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,1));

    // Reset during MEMRD aborts asynchronously with no writeback
    do_reset();
    fetch_decode("rstmid", 6'b100011, 6'd0);
    cyc("rstmid.memadr", 2, cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
    mem_ready = 1'b0;
    #1;
    check_eq("rstmid.memrd.state", 32'(state), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rstmid.async.state", 32'(state), 32'd0);
    check_eq("rstmid.async.regw", 32'(reg_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc("rstmid.after0", 0, cv(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0));
    cyc("rstmid.after1", 0, cv(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath control line each cycle. It also selects zero- versus sign-extension of the 16-bit immediate via `ext_zero`, which is high only for ORI. It sits beside the datapath, taking the latched opcode/funct, the ALU `zero` flag and a memory ready handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: instruction[31:26] from the instruction register.
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_en` out 1: PC load enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: destination register. 1 = rd, 0 = rt.
- `mem_to_reg` out 1: writeback source. 1 = data register.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A input. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B input. 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `alu_control` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ext_zero` out 1: 1 = zero-extend immediate, 0 = sign-extend.
- `state` out 4: current state code, for debug.
- `retire` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` out 1: high while halted on an unsupported instruction.

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ORI 001101, J 000010.
- R-type funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, HALT 15.
- Outputs are a Moore decode of `state`, except where gated by `mem_ready`, `zero` or `op` as listed.
- Any output not listed for a state is 0.
- FETCH:
  - Drives iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, add, ext_zero=0 (precomputes the branch target).
  - Next state by op: LW/SW to MEMADR, RTYPE to EXEC_R, BEQ to BRANCH, ADDI/ORI to IMMEXEC, J to JUMP.
  - An RTYPE with unsupported funct, or any other op, goes to HALT.
- MEMADR: drives alu_src_a=1, alu_src_b=10, add, ext_zero=0. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: drives iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: drives reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Goes to FETCH.
- MEMWR:
  - Drives iord=1, mem_write=1.
  - Waits for mem_ready; mem_write stays asserted throughout the wait.
  - On mem_ready: retire=1, then FETCH.
- EXEC_R: drives alu_src_a=1, alu_src_b=00, alu_control from funct. Goes to ALUWB.
- ALUWB: drives reg_dst=1, reg_write=1, retire=1. Goes to FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_en = zero, retire=1.
  - Goes to FETCH.
- IMMEXEC:
  - Drives alu_src_a=1, alu_src_b=10.
  - ADDI: add, ext_zero=0. ORI: or, ext_zero=1.
  - Goes to IMMWB.
- IMMWB: drives reg_dst=0, reg_write=1, retire=1. ext_zero holds its IMMEXEC value. Goes to FETCH.
- JUMP: drives pc_src=10, pc_en=1, retire=1. Goes to FETCH.
- HALT: illegal=1, all write enables 0. Leaves only on reset.
- `op`/`funct` are sampled combinationally. The IR holds them stable from DECODE onward.

## Timing
- Reset (asynchronous) forces state=FETCH immediately.
- While reset is high, pc_en, ir_write, mem_write and reg_write are forced to 0.
- Other outputs show FETCH values while reset is high.
- One state transition per rising edge once reset is released.
- Zero-wait-state cycle counts (mem_ready tied high):
  - LW: 5 cycles.
  - SW: 4 cycles.
  - R-type, ADDI, ORI: 4 cycles.
  - BEQ, J: 3 cycles.
- Each cycle of low mem_ready in FETCH, MEMRD or MEMWR adds one cycle.
- retire is high in exactly one cycle per instruction, and that cycle is its final cycle. A halted instruction never retires.
- Reset asserted mid-instruction aborts it with no register or memory write.

## Test plan
- Reset, then mem_ready=1, op=LW → states 0,1,2,3,4,0. reg_write and mem_to_reg high only in state 4; retire high in state 4.
- SW with mem_ready low for 3 cycles in MEMWR → mem_write high for 4 consecutive cycles; retire only on the mem_ready cycle.
- ORI then ADDI → ext_zero=1 and alu_control=001 in IMMEXEC/IMMWB for ORI; ext_zero=0 and 010 for ADDI.
- BEQ with zero=1, then BEQ with zero=0 → pc_en=1 with pc_src=01 in the first BRANCH; pc_en=0 in the second. Each takes 3 cycles.
- R-type funct=101010 → alu_control=111 in EXEC_R. Then op=111111 → state 15 and illegal=1 held for 10 cycles with no write enables.
- Assert reset during MEMRD → state reads 0 asynchronously before the next edge; no reg_write follows.
